// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states, forwarding selects, shadow flag layout.
// The HAZARD_FORWARDING_EN build option is consumed by pipeline_hazard_ctrl.sv.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_FREEZE = 2'd3
   } state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // Shadow entry flags are packed as {valid, regwrite, is_load}.
   localparam int SHADOW_FLAG_W = 3;
   localparam int FLAG_VALID    = 2;
   localparam int FLAG_REGWRITE = 1;
   localparam int FLAG_LOAD     = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_stage_shadow.sv
// One pipeline stage's shadow entry ({valid, regwrite, is_load} plus rd), with load enable and bubble insert.
module stage_shadow
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en_i,
   input  logic                     bubble_i,
   input  logic [SHADOW_FLAG_W-1:0] flags_i,
   input  logic [REG_W-1:0]         rd_i,
   output logic [SHADOW_FLAG_W-1:0] flags_o,
   output logic [REG_W-1:0]         rd_o
);

   logic [SHADOW_FLAG_W-1:0] flags_q, flags_d;
   logic [REG_W-1:0]         rd_q, rd_d;

   always_comb begin
      flags_d = flags_q;
      rd_d    = rd_q;
      if (en_i) begin
         if (bubble_i) begin
            flags_d = '0;
            rd_d    = '0;
         end else begin
            flags_d = flags_i;
            rd_d    = rd_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         flags_q <= '0;
         rd_q    <= '0;
      end else begin
         flags_q <= flags_d;
         rd_q    <= rd_d;
      end
   end

   assign flags_o = flags_q;
   assign rd_o    = rd_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: RAW stalls, branch flushes, memory freezes and optional forwarding.
// Define HAZARD_FORWARDING_EN to stall only on load-use and drive fwd_a/fwd_b; otherwise full RAW stalling.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_W   = 4,
   parameter bit R0_ZERO = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_regwrite,
   input  logic             id_is_load,
   input  logic             br_taken,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             pipe_en,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt
);

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
   logic [SHADOW_FLAG_W-1:0] id_flags, ex_flags, mem_flags, wb_flags;
   logic [REG_W-1:0]         ex_rd, mem_rd, wb_rd;
   logic                     id_live, src1_live, src2_live, hazard, advance, issue;
   logic [1:0]               fwd_a_d, fwd_b_d;

   function automatic logic srcLive(input logic use_i, input logic [REG_W-1:0] idx);
      return use_i && !(R0_ZERO && (idx == '0));
   endfunction

   function automatic logic writesReg(input logic [SHADOW_FLAG_W-1:0] flags,
                                      input logic [REG_W-1:0] rd, input logic [REG_W-1:0] idx);
      return flags[FLAG_VALID] && flags[FLAG_REGWRITE] && (rd == idx);
   endfunction

   // The cycle after a flush, ID holds the bubble the flush loaded, so a stale id_valid is ignored.
   assign id_live   = id_valid && (state_q != ST_FLUSH);
   assign src1_live = srcLive(id_use_rs1, id_rs1);
   assign src2_live = srcLive(id_use_rs2, id_rs2);
   assign id_flags  = {1'b1, id_regwrite, id_is_load};

`ifdef HAZARD_FORWARDING_EN
   always_comb begin
      hazard = (src1_live && writesReg(ex_flags, ex_rd, id_rs1) && ex_flags[FLAG_LOAD]) ||
               (src2_live && writesReg(ex_flags, ex_rd, id_rs2) && ex_flags[FLAG_LOAD]);
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
      if (src1_live && writesReg(mem_flags, mem_rd, id_rs1))     fwd_a_d = FWD_MEM;
      else if (src1_live && writesReg(wb_flags, wb_rd, id_rs1))  fwd_a_d = FWD_WB;
      if (src2_live && writesReg(mem_flags, mem_rd, id_rs2))     fwd_b_d = FWD_MEM;
      else if (src2_live && writesReg(wb_flags, wb_rd, id_rs2))  fwd_b_d = FWD_WB;
   end
`else
   // The register file is not write-first, so a producer still in WB blocks the read.
   always_comb begin
      hazard = (src1_live && (writesReg(ex_flags, ex_rd, id_rs1) ||
                              writesReg(mem_flags, mem_rd, id_rs1) ||
                              writesReg(wb_flags, wb_rd, id_rs1))) ||
               (src2_live && (writesReg(ex_flags, ex_rd, id_rs2) ||
                              writesReg(mem_flags, mem_rd, id_rs2) ||
                              writesReg(wb_flags, wb_rd, id_rs2)));
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
   end
`endif

   always_comb begin
      state_d = ST_RUN;
      if (mem_busy)                state_d = ST_FREEZE;
      else if (br_taken)           state_d = ST_FLUSH;
      else if (id_live && hazard)  state_d = ST_STALL;
   end

   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      pipe_en    = 1'b1;
      advance    = 1'b1;
      issue      = 1'b0;
      fwd_a      = fwd_a_d;
      fwd_b      = fwd_b_d;
      case (state_d)
         ST_FREEZE: begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
            advance = 1'b0;
         end
         ST_FLUSH: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end
         ST_STALL: begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
         default: issue = id_live;
      endcase
      if (!rst) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         pipe_en    = 1'b0;
         fwd_a      = FWD_RF;
         fwd_b      = FWD_RF;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_d == ST_STALL) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

   stage_shadow #(.REG_W(REG_W)) u_ex (
      .clk(clk), .rst(rst), .en_i(advance), .bubble_i(!issue),
      .flags_i(id_flags), .rd_i(id_rd), .flags_o(ex_flags), .rd_o(ex_rd)
   );

   stage_shadow #(.REG_W(REG_W)) u_mem (
      .clk(clk), .rst(rst), .en_i(advance), .bubble_i(1'b0),
      .flags_i(ex_flags), .rd_i(ex_rd), .flags_o(mem_flags), .rd_o(mem_rd)
   );

   stage_shadow #(.REG_W(REG_W)) u_wb (
      .clk(clk), .rst(rst), .en_i(advance), .bubble_i(1'b0),
      .flags_i(mem_flags), .rd_i(mem_rd), .flags_o(wb_flags), .rd_o(wb_rd)
   );

endmodule
